mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Self-timed address/mode sequencer for the MLP datapath. Nested counters (image > neuron > chunk)
//  replace externally supplied I/N/Q indices. Drives I/W1/W2 memory addresses, multiplier mode and adder mode.
//  Sits between the host start/done handshake and the multiplier/adder datapath.
//  Flags layer-2 readiness once every neuron of an image has drained from the adder.
// PARAMETERS
//  NUM_IMG       10   images per run; img_addr runs 1..NUM_IMG
//  NUM_NEURON    200  hidden neurons per image; neuron_addr runs 1..NUM_NEURON
//  NUM_CHUNK     8    input chunks per neuron; must be >= 1
//  CHUNK_STRIDE  98   byte_addr step between chunks
//  BYTE_BASE     1    byte_addr of chunk 1
//  ADDR_W        10   byte_addr width; must hold BYTE_BASE+(NUM_CHUNK-1)*CHUNK_STRIDE
//  IMG_W         4    img_addr width
//  NEU_W         8    neuron_addr width
//  PIPE_LAT      2    cycles from last accepted chunk to the adder result being valid
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous, active-high reset
//  start         in   1       one-cycle run request; sampled only in IDLE
//  adder_ready   in   1       datapath accepts the current chunk this cycle (advance enable)
//  img_addr      out  IMG_W   image index to I memory
//  byte_addr     out  ADDR_W  byte offset into I memory and W1
//  neuron_addr   out  NEU_W   neuron index to W1 and byte index to W2
//  mult_mode     out  1       0 on last chunk, else 1
//  adder_mode    out  2       00 clear, 01 new neuron, 10 accumulate, 11 finalise
//  issue_valid   out  1       addresses/modes valid this cycle
//  layer2_ready  out  1       one-cycle pulse: all neurons of the current image drained
//  busy          out  1       high in RUN or DRAIN
//  done          out  1       one-cycle pulse after last image drains
//  stall_cnt     out  16      present only with MLP_SEQ_STALL_CNT_EN
// BEHAVIOUR
//  Reset values: img_addr=1, neuron_addr=1, byte_addr=BYTE_BASE, mult_mode=1, adder_mode=00.
//    All 1-bit status outputs reset to 0; state=IDLE.
//  Reset mid-run: sync rst aborts immediately to IDLE. No done or layer2_ready pulse is produced.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//    IDLE->RUN on start. Counters are already at 1/1/1, so the first issue occurs in the RUN cycle.
//    RUN: issue_valid=1. When adder_ready=1, the chunk counter advances.
//      Chunk wraps to 1 -> neuron advances. Neuron wraps -> enter DRAIN.
//      Outputs are registered, and all three counters update in the same edge.
//    RUN with adder_ready=0: every output holds.
//    DRAIN: issue_valid=0 for PIPE_LAT cycles, then pulse layer2_ready.
//      Not the last image: img++, neuron=chunk=1, return to RUN.
//      Last image: go to DONE.
//    DONE: done=1 for one cycle -> IDLE; img resets to 1.
//  byte_addr is computed incrementally (+CHUNK_STRIDE per advance, BYTE_BASE on wrap). No multiplier.
//  adder_mode priority is: last chunk 11, then first chunk of neuron 1 => 00, then first chunk 01, else 10.
//  NUM_CHUNK=1: every issue is 11 and mult_mode=0.
//  busy = (state==RUN || state==DRAIN).
//  start while busy is ignored. Simultaneous rst and start resolve to reset.
// CONFIGURATION
//  MLP_SEQ_STALL_CNT_EN defined:
//    stall_cnt counts cycles in RUN with adder_ready=0. It saturates at 16'hFFFF.
//    It clears on rst and on IDLE->RUN, and holds after done.
//  MLP_SEQ_STALL_CNT_EN undefined: no port and no counter logic.
// STRUCTURE
//  mlp_pkg holds:
//    adder_mode_t localparams ADD_CLR/ADD_NEW/ADD_ACC/ADD_FIN.
//    seq_state_t (IDLE/RUN/DRAIN/DONE).
//    Default NUM_* and CHUNK_STRIDE constants.
//  Sub-module mlp_wrap_counter(WIDTH, MAX) has inputs clr and en, and outputs val (1..MAX) and last.
//    It is instantiated for the chunk, neuron and image counters and for the drain counter.
// TESTING
//  1. NUM_CHUNK=8, NUM_NEURON=2, NUM_IMG=1, adder_ready=1, start:
//     byte_addr 1,99,197,...,687 twice; adder_mode 00,10x6,11 then 01,10x6,11.
//     mult_mode=0 only at 687. layer2_ready 2 cycles after the last issue; done next cycle.
//  2. Toggle adder_ready 1/0 each cycle:
//     outputs hold on every 0 cycle. Sequence matches test 1 with 2x duration; stall_cnt=16 (macro on).
//  3. NUM_IMG=3 defaults otherwise:
//     img_addr 1->2->3, 1600 issues per image.
//     Exactly 3 layer2_ready pulses and 1 done pulse; busy low afterwards.
//  4. Assert rst at issue 500:
//     next cycle all outputs at reset values. A new start restarts at img 1, neuron 1, byte 1.
//  5. start pulsed during RUN and DRAIN: no effect on sequence. NUM_CHUNK=1: every adder_mode=11 and mult_mode=0.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and defaults for the MLP layer sequencer.
// Optional stall counter is enabled with MLP_SEQ_STALL_CNT_EN.
package mlp_pkg;

  typedef logic [1:0] adder_mode_t;

  localparam adder_mode_t ADD_CLR = 2'b00;
  localparam adder_mode_t ADD_NEW = 2'b01;
  localparam adder_mode_t ADD_ACC = 2'b10;
  localparam adder_mode_t ADD_FIN = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int NUM_IMG_DEF      = 10;
  localparam int NUM_NEURON_DEF   = 200;
  localparam int NUM_CHUNK_DEF    = 8;
  localparam int CHUNK_STRIDE_DEF = 98;
  localparam int BYTE_BASE_DEF    = 1;
  localparam int PIPE_LAT_DEF     = 2;

  // Last chunk outranks first chunk so NUM_CHUNK=1 always finalises
  function automatic adder_mode_t mode_of(
    input logic chunk_last,
    input logic chunk_first,
    input logic neuron_first
  );
    adder_mode_t m;
    if (chunk_last)
      m = ADD_FIN;
    else if (chunk_first && neuron_first)
      m = ADD_CLR;
    else if (chunk_first)
      m = ADD_NEW;
    else
      m = ADD_ACC;
    return m;
  endfunction

endpackage

// File: rtl/mlp_wrap_counter.sv
// Counter running 1..MAX, wrapping to 1; clr forces 1.
// Used for chunk, neuron, image and drain timing.
module mlp_wrap_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] val,
  output logic             last
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  assign last = (val_q == WIDTH'(MAX));
  assign val  = val_q;

  always_comb begin
    val_d = val_q;
    if (clr)
      val_d = WIDTH'(1);
    else if (en)
      val_d = last ? WIDTH'(1) : val_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      val_q <= WIDTH'(1);
    else
      val_q <= val_d;
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Image > neuron > chunk address/mode sequencer for the MLP datapath.
// Define MLP_SEQ_STALL_CNT_EN to add the stall_cnt port and counter.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_IMG      = NUM_IMG_DEF,
  parameter int NUM_NEURON   = NUM_NEURON_DEF,
  parameter int NUM_CHUNK    = NUM_CHUNK_DEF,
  parameter int CHUNK_STRIDE = CHUNK_STRIDE_DEF,
  parameter int BYTE_BASE    = BYTE_BASE_DEF,
  parameter int ADDR_W       = 10,
  parameter int IMG_W        = 4,
  parameter int NEU_W        = 8,
  parameter int PIPE_LAT     = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adder_ready,
  output logic [IMG_W-1:0]  img_addr,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [NEU_W-1:0]  neuron_addr,
  output logic              mult_mode,
  output logic [1:0]        adder_mode,
  output logic              issue_valid,
  output logic              layer2_ready,
  output logic              busy,
  output logic              done
`ifdef MLP_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CHK_W = $clog2(NUM_CHUNK + 1);
  localparam int DRN_W = $clog2(PIPE_LAT + 1);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [ADDR_W-1:0] byte_q;
  logic [ADDR_W-1:0] byte_d;

  logic [CHK_W-1:0] chunk_val;
  logic [DRN_W-1:0] drain_val_unused;
  logic chunk_last;
  logic neuron_last;
  logic img_last;
  logic drain_last;

  logic in_run;
  logic in_drain;
  logic advance;
  logic start_run;
  logic img_en;

  assign in_run    = (state_q == RUN);
  assign in_drain  = (state_q == DRAIN);
  assign advance   = in_run & adder_ready;
  assign start_run = (state_q == IDLE) & start;
  assign img_en    = in_drain & drain_last & ~img_last;

  mlp_wrap_counter #(.WIDTH(CHK_W), .MAX(NUM_CHUNK)) u_chunk (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_run),
    .en   (advance),
    .val  (chunk_val),
    .last (chunk_last)
  );

  mlp_wrap_counter #(.WIDTH(NEU_W), .MAX(NUM_NEURON)) u_neuron (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_run),
    .en   (advance & chunk_last),
    .val  (neuron_addr),
    .last (neuron_last)
  );

  mlp_wrap_counter #(.WIDTH(IMG_W), .MAX(NUM_IMG)) u_img (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_run | (state_q == DONE)),
    .en   (img_en),
    .val  (img_addr),
    .last (img_last)
  );

  // Held at 1 outside DRAIN so every drain lasts exactly PIPE_LAT cycles
  mlp_wrap_counter #(.WIDTH(DRN_W), .MAX(PIPE_LAT)) u_drain (
    .clk  (clk),
    .rst  (rst),
    .clr  (~in_drain),
    .en   (in_drain),
    .val  (drain_val_unused),
    .last (drain_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (advance && chunk_last && neuron_last)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last)
          state_d = img_last ? DONE : RUN;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte offset stepped by addition only
  always_comb begin
    byte_d = byte_q;
    if (start_run)
      byte_d = ADDR_W'(BYTE_BASE);
    else if (advance)
      byte_d = chunk_last ? ADDR_W'(BYTE_BASE)
                          : byte_q + ADDR_W'(CHUNK_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= ADDR_W'(BYTE_BASE);
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end

  assign byte_addr    = byte_q;
  assign issue_valid  = in_run;
  assign busy         = in_run | in_drain;
  assign layer2_ready = in_drain & drain_last;
  assign done         = (state_q == DONE);
  assign mult_mode    = ~(in_run & chunk_last);
  assign adder_mode   = in_run
    ? mode_of(chunk_last,
              chunk_val == CHK_W'(1),
              neuron_addr == NEU_W'(1))
    : ADD_CLR;

`ifdef MLP_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_run)
      stall_d = '0;
    else if (in_run && !adder_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else
      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: three parameterisations
// (small, default with 3 images, single-chunk) sharing clk/rst.
module tb_mlp_layer_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // small: 8 chunks, 2 neurons, 1 image
  logic s_start, s_rdy, s_mult, s_iv, s_l2, s_busy, s_done;
  logic [3:0] s_img;
  logic [9:0] s_byte;
  logic [7:0] s_neu;
  logic [1:0] s_mode;
  logic [15:0] s_stall;

  // full: default sizes, 3 images
  logic f_start, f_rdy, f_mult, f_iv, f_l2, f_busy, f_done;
  logic [3:0] f_img;
  logic [9:0] f_byte;
  logic [7:0] f_neu;
  logic [1:0] f_mode;
  logic [15:0] f_stall;

  // one: 1 chunk, 3 neurons, 2 images
  logic o_start, o_rdy, o_mult, o_iv, o_l2, o_busy, o_done;
  logic [3:0] o_img;
  logic [9:0] o_byte;
  logic [7:0] o_neu;
  logic [1:0] o_mode;
  logic [15:0] o_stall;

  mlp_layer_sequencer #(
    .NUM_IMG(1), .NUM_NEURON(2), .NUM_CHUNK(8)
  ) u_s (
    .clk(clk), .rst(rst), .start(s_start), .adder_ready(s_rdy),
    .img_addr(s_img), .byte_addr(s_byte), .neuron_addr(s_neu),
    .mult_mode(s_mult), .adder_mode(s_mode), .issue_valid(s_iv),
    .layer2_ready(s_l2), .busy(s_busy), .done(s_done)
`ifdef MLP_SEQ_STALL_CNT_EN
    , .stall_cnt(s_stall)
`endif
  );

  mlp_layer_sequencer #(
    .NUM_IMG(3)
  ) u_f (
    .clk(clk), .rst(rst), .start(f_start), .adder_ready(f_rdy),
    .img_addr(f_img), .byte_addr(f_byte), .neuron_addr(f_neu),
    .mult_mode(f_mult), .adder_mode(f_mode), .issue_valid(f_iv),
    .layer2_ready(f_l2), .busy(f_busy), .done(f_done)
`ifdef MLP_SEQ_STALL_CNT_EN
    , .stall_cnt(f_stall)
`endif
  );

  mlp_layer_sequencer #(
    .NUM_IMG(2), .NUM_NEURON(3), .NUM_CHUNK(1)
  ) u_o (
    .clk(clk), .rst(rst), .start(o_start), .adder_ready(o_rdy),
    .img_addr(o_img), .byte_addr(o_byte), .neuron_addr(o_neu),
    .mult_mode(o_mult), .adder_mode(o_mode), .issue_valid(o_iv),
    .layer2_ready(o_l2), .busy(o_busy), .done(o_done)
`ifdef MLP_SEQ_STALL_CNT_EN
    , .stall_cnt(o_stall)
`endif
  );

  typedef struct {
    logic [9:0] byt;
    logic [1:0] mode;
    logic       mult;
    logic [7:0] neu;
  } vec_t;

  vec_t vec[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string p, input logic [3:0] img,
                         input logic [9:0] byt, input logic [7:0] neu,
                         input logic mult, input logic [1:0] mode,
                         input logic [3:0] stat);
    chk({p, "_img"}, img, 1);
    chk({p, "_byte"}, byt, 1);
    chk({p, "_neu"}, neu, 1);
    chk({p, "_mult"}, mult, 1);
    chk({p, "_mode"}, mode, 0);
    chk({p, "_status"}, stat, 0);
  endtask

  task automatic run_small(input bit tog, input bit poke);
    int idx = 0;
    int cyc = 0;
    int stalls = 0;
    logic rdy;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (idx < 16 && cyc < 200) begin
      chk("s_issue", s_iv, 1);
      chk("s_busy", s_busy, 1);
      chk("s_byte", s_byte, vec[idx].byt);
      chk("s_mode", s_mode, vec[idx].mode);
      chk("s_mult", s_mult, vec[idx].mult);
      chk("s_neu", s_neu, vec[idx].neu);
      rdy = tog ? (cyc % 2 == 1) : 1'b1;
      s_rdy = rdy;
      s_start = poke && (cyc == 5);
      if (!rdy) stalls++;
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
    end
    chk("s_issues", idx, 16);
    s_start = poke;
    chk("s_drain1_iv", s_iv, 0);
    chk("s_drain1_l2", s_l2, 0);
    chk("s_drain1_busy", s_busy, 1);
    @(negedge clk);
    s_start = 1'b0;
    chk("s_drain2_iv", s_iv, 0);
    chk("s_drain2_l2", s_l2, 1);
    chk("s_drain2_done", s_done, 0);
    @(negedge clk);
    chk("s_done", s_done, 1);
    chk("s_done_l2", s_l2, 0);
    chk("s_done_busy", s_busy, 0);
    @(negedge clk);
    chk("s_idle_done", s_done, 0);
    chk("s_idle_busy", s_busy, 0);
    chk("s_idle_img", s_img, 1);
`ifdef MLP_SEQ_STALL_CNT_EN
    chk("s_stall_cnt", s_stall, stalls);
`endif
  endtask

  initial begin
    int ei, en, ec, errs, l2s, dn, iss, cyc;
    int per[3];
    rst = 1'b1;
    s_start = 0; s_rdy = 0;
    f_start = 0; f_rdy = 0;
    o_start = 0; o_rdy = 0;
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < 8; c++) begin
        vec[n*8+c].byt  = 10'(1 + 98 * c);
        vec[n*8+c].mode = (c == 7) ? 2'b11
                        : (c == 0) ? ((n == 0) ? 2'b00 : 2'b01)
                        : 2'b10;
        vec[n*8+c].mult = (c != 7);
        vec[n*8+c].neu  = 8'(n + 1);
      end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_rst("s_rst", s_img, s_byte, s_neu, s_mult, s_mode,
            {s_iv, s_l2, s_busy, s_done});
    chk_rst("o_rst", o_img, o_byte, o_neu, o_mult, o_mode,
            {o_iv, o_l2, o_busy, o_done});
`ifdef MLP_SEQ_STALL_CNT_EN
    chk("s_rst_stall", s_stall, 0);
`endif

    run_small(1'b0, 1'b0);
    run_small(1'b1, 1'b0);
    run_small(1'b0, 1'b1);

    // three full images
    f_rdy = 1'b1;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    ei = 1; en = 1; ec = 1; errs = 0;
    l2s = 0; dn = 0; iss = 0;
    per = '{0, 0, 0};
    for (int c = 0; c < 6000 && dn == 0; c++) begin
      if (f_iv) begin
        if (f_img != 4'(ei) || f_neu != 8'(en) ||
            f_byte != 10'(1 + 98 * (ec - 1)))
          errs++;
        if (l2s < 3) per[l2s]++;
        if (ec == 8) begin
          ec = 1;
          en = (en == 200) ? 1 : en + 1;
        end else ec++;
      end
      if (f_l2) begin
        if (f_img != 4'(ei)) errs++;
        l2s++;
        ei++;
      end
      if (f_done) dn++;
      @(negedge clk);
    end
    chk("f_seq_errs", errs, 0);
    chk("f_l2_pulses", l2s, 3);
    chk("f_done_pulses", dn, 1);
    chk("f_img1_issues", per[0], 1600);
    chk("f_img2_issues", per[1], 1600);
    chk("f_img3_issues", per[2], 1600);
    chk("f_after_busy", f_busy, 0);
    chk("f_after_img", f_img, 1);

    // abort at issue 500
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    iss = 0;
    cyc = 0;
    while (iss < 499 && cyc < 1000) begin
      if (f_iv) iss++;
      cyc++;
      @(negedge clk);
    end
    chk("f_i500_byte", f_byte, 295);
    chk("f_i500_neu", f_neu, 63);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_rst("f_abort", f_img, f_byte, f_neu, f_mult, f_mode,
            {f_iv, f_l2, f_busy, f_done});
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    chk("f_restart_iv", f_iv, 1);
    chk("f_restart_img", f_img, 1);
    chk("f_restart_neu", f_neu, 1);
    chk("f_restart_byte", f_byte, 1);
    chk("f_restart_mode", f_mode, 0);
    rst = 1'b1;
    f_start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    f_start = 1'b0;
    chk("f_rst_start_busy", f_busy, 0);

    // single chunk per neuron
    o_rdy = 1'b1;
    o_start = 1'b1;
    @(negedge clk);
    o_start = 1'b0;
    en = 1; iss = 0; l2s = 0; dn = 0;
    for (int c = 0; c < 40 && dn == 0; c++) begin
      if (o_iv) begin
        chk("o_mode", o_mode, 3);
        chk("o_mult", o_mult, 0);
        chk("o_neu", o_neu, en);
        chk("o_byte", o_byte, 1);
        en = (en == 3) ? 1 : en + 1;
        iss++;
      end
      if (o_l2) l2s++;
      if (o_done) dn++;
      @(negedge clk);
    end
    chk("o_issues", iss, 6);
    chk("o_l2_pulses", l2s, 2);
    chk("o_done_pulses", dn, 1);
    chk("o_after_busy", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
